axis_wb_resp_parser: RTL

Downstream consumer of the axis_wb_master response stream. Parses 8-bit AXI-stream response frames (READ_RESP / WRITE_RESP) into a per-frame status record and a stream of packed WB-width read-data words. Sits between the bridge's output_axis and host-side logic that needs word-aligned read data. It also flags malformed frames.

---
 rtl/axis_wb_resp_parser_pkg.sv | 30 +++
 rtl/axis_byte_packer.sv | 76 +++++++
 rtl/axis_wb_resp_parser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/axis_wb_resp_parser_pkg.sv
// Shared definitions for the axis_wb_master response-stream parser:
// response type codes, status error bit positions and the parser state encoding.
package axis_wb_resp_parser_pkg;

    localparam logic [7:0] READ_RESP_CODE  = 8'hA3;
    localparam logic [7:0] WRITE_RESP_CODE = 8'hA4;

    localparam int unsigned ERR_BAD_TYPE = 0;
    localparam int unsigned ERR_SHORT    = 1;
    localparam int unsigned ERR_LONG     = 2;
    localparam int unsigned ERR_TUSER    = 3;

    typedef enum logic [2:0] {
        ST_TYPE,
        ST_COUNT,
        ST_ADDR,
        ST_DATA,
        ST_DROP,
        ST_STATUS
    } state_t;

    function automatic logic is_known_type(
        input logic [7:0] t,
        input logic [7:0] rd_code,
        input logic [7:0] wr_code
    );
        return (t == rd_code) || (t == wr_code);
    endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Packs a byte stream into DATA_WIDTH words, first byte in lane 0, with a single
// registered output stage carrying tkeep/tlast.
module axis_byte_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int LANE_W = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] acc_data;
    logic [KEEP_WIDTH-1:0] acc_keep;
    logic [LANE_W-1:0]     lane;
    logic [DATA_WIDTH-1:0] next_data;
    logic [KEEP_WIDTH-1:0] next_keep;
    logic                  lane_full;

    // A new byte may only arrive when a completed word can move into the output register.
    assign in_ready  = !out_valid || out_ready;
    assign lane_full = (lane == LANE_W'(KEEP_WIDTH - 1));

    always_comb begin
        next_data = acc_data;
        next_keep = acc_keep;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            if (lane == LANE_W'(i)) begin
                next_data[8*i +: 8] = in_data;
                next_keep[i]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_data  <= '0;
            acc_keep  <= '0;
            lane      <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (in_valid) begin
                if (lane_full || in_last) begin
                    out_data  <= next_data;
                    out_keep  <= next_keep;
                    out_valid <= 1'b1;
                    out_last  <= in_last;
                    acc_data  <= '0;
                    acc_keep  <= '0;
                    lane      <= '0;
                end else begin
                    acc_data <= next_data;
                    acc_keep <= next_keep;
                    lane     <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_wb_resp_parser.sv
// Parses axis_wb_master READ_RESP/WRITE_RESP byte frames into a status record
// plus packed read-data words, flagging bad type, short, long and tuser frames.
module axis_wb_resp_parser
    import axis_wb_resp_parser_pkg::*;
#(
    parameter int         COUNT_SIZE      = 16,
    parameter int         WB_DATA_WIDTH   = 32,
    parameter int         WB_ADDR_WIDTH   = 32,
    parameter int         WB_SELECT_WIDTH = WB_DATA_WIDTH / 8,
    parameter logic [7:0] READ_RESP       = READ_RESP_CODE,
    parameter logic [7:0] WRITE_RESP      = WRITE_RESP_CODE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 input_axis_tdata,
    input  logic                       input_axis_tvalid,
    output logic                       input_axis_tready,
    input  logic                       input_axis_tlast,
    input  logic                       input_axis_tuser,
    output logic [WB_DATA_WIDTH-1:0]   output_axis_tdata,
    output logic [WB_SELECT_WIDTH-1:0] output_axis_tkeep,
    output logic                       output_axis_tvalid,
    input  logic                       output_axis_tready,
    output logic                       output_axis_tlast,
    output logic                       status_valid,
    input  logic                       status_ready,
    output logic [7:0]                 status_type,
    output logic [COUNT_SIZE-1:0]      status_count,
    output logic [WB_ADDR_WIDTH-1:0]   status_addr,
    output logic [3:0]                 status_error,
    output logic                       busy
);

    localparam int unsigned COUNT_BYTES = COUNT_SIZE / 8;
    localparam int unsigned ADDR_BYTES  = WB_ADDR_WIDTH / 8;

    state_t                state;
    logic [7:0]            hdr_cnt;
    logic [COUNT_SIZE-1:0] remaining;
    logic                  accept;
    logic                  pk_in_valid;
    logic                  pk_in_last;
    logic                  pk_in_ready;
    logic                  last_payload;

    always_comb begin
        input_axis_tready = 1'b0;
        case (state)
            ST_TYPE, ST_COUNT, ST_ADDR, ST_DROP: input_axis_tready = 1'b1;
            ST_DATA:                             input_axis_tready = pk_in_ready;
            default:                             input_axis_tready = 1'b0;
        endcase
    end

    assign accept       = input_axis_tvalid && input_axis_tready;
    assign last_payload = (remaining == COUNT_SIZE'(1));
    assign pk_in_valid  = accept && (state == ST_DATA);
    // Either end of payload (long frames included) or an early tlast closes the word.
    assign pk_in_last   = input_axis_tlast || last_payload;
    assign busy         = (state != ST_TYPE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_TYPE;
            hdr_cnt      <= '0;
            remaining    <= '0;
            status_valid <= 1'b0;
            status_type  <= '0;
            status_count <= '0;
            status_addr  <= '0;
            status_error <= '0;
        end else begin
            case (state)
                ST_TYPE: begin
                    if (accept) begin
                        status_type  <= input_axis_tdata;
                        status_count <= '0;
                        status_addr  <= '0;
                        status_error <= '0;
                        hdr_cnt      <= '0;
                        if (!is_known_type(input_axis_tdata, READ_RESP, WRITE_RESP)) begin
                            status_error[ERR_BAD_TYPE] <= 1'b1;
                            if (input_axis_tlast) begin
                                status_error[ERR_TUSER] <= input_axis_tuser;
                                state                   <= ST_STATUS;
                            end else begin
                                state <= ST_DROP;
                            end
                        end else if (input_axis_tlast) begin
                            status_error[ERR_SHORT] <= 1'b1;
                            status_error[ERR_TUSER] <= input_axis_tuser;
                            state                   <= ST_STATUS;
                        end else begin
                            state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        status_count <= (status_count << 8) | COUNT_SIZE'(input_axis_tdata);
                        if (input_axis_tlast) begin
                            status_error[ERR_SHORT] <= 1'b1;
                            status_error[ERR_TUSER] <= input_axis_tuser;
                            state                   <= ST_STATUS;
                        end else if (hdr_cnt == 8'(COUNT_BYTES - 1)) begin
                            hdr_cnt <= '0;
                            state   <= ST_ADDR;
                        end else begin
                            hdr_cnt <= hdr_cnt + 8'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        status_addr <= (status_addr << 8) | WB_ADDR_WIDTH'(input_axis_tdata);
                        if (hdr_cnt == 8'(ADDR_BYTES - 1)) begin
                            if (status_type == READ_RESP && status_count != '0) begin
                                remaining <= status_count;
                                if (input_axis_tlast) begin
                                    status_error[ERR_SHORT] <= 1'b1;
                                    status_error[ERR_TUSER] <= input_axis_tuser;
                                    state                   <= ST_STATUS;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end else if (input_axis_tlast) begin
                                status_error[ERR_TUSER] <= input_axis_tuser;
                                state                   <= ST_STATUS;
                            end else begin
                                status_error[ERR_LONG] <= 1'b1;
                                state                  <= ST_DROP;
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + 8'd1;
                            if (input_axis_tlast) begin
                                status_error[ERR_SHORT] <= 1'b1;
                                status_error[ERR_TUSER] <= input_axis_tuser;
                                state                   <= ST_STATUS;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        remaining <= remaining - COUNT_SIZE'(1);
                        if (last_payload) begin
                            if (input_axis_tlast) begin
                                status_error[ERR_TUSER] <= input_axis_tuser;
                                state                   <= ST_STATUS;
                            end else begin
                                status_error[ERR_LONG] <= 1'b1;
                                state                  <= ST_DROP;
                            end
                        end else if (input_axis_tlast) begin
                            status_error[ERR_SHORT] <= 1'b1;
                            status_error[ERR_TUSER] <= input_axis_tuser;
                            state                   <= ST_STATUS;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && input_axis_tlast) begin
                        status_error[ERR_TUSER] <= input_axis_tuser;
                        state                   <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    // Hold the record back until the frame's final word has left the packer.
                    if (status_valid && status_ready) begin
                        status_valid <= 1'b0;
                        state        <= ST_TYPE;
                    end else if (!status_valid && !output_axis_tvalid) begin
                        status_valid <= 1'b1;
                    end
                end
                default: state <= ST_TYPE;
            endcase
        end
    end

    axis_byte_packer #(
        .DATA_WIDTH(WB_DATA_WIDTH),
        .KEEP_WIDTH(WB_SELECT_WIDTH)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .in_data  (input_axis_tdata),
        .in_valid (pk_in_valid),
        .in_last  (pk_in_last),
        .in_ready (pk_in_ready),
        .out_data (output_axis_tdata),
        .out_keep (output_axis_tkeep),
        .out_valid(output_axis_tvalid),
        .out_last (output_axis_tlast),
        .out_ready(output_axis_tready)
    );

endmodule
